// File: rtl/prod_accum_pkg.sv
// Shared types and widths for the product accumulator.
//   state_t : accumulator FSM states (IDLE, ACCUM, HOLD)
//   PROD_W  : width of one incoming product
//   SUM_W   : width of the accumulated sum (256 full-scale products fit)
//   CNT_W   : width of the product counter (holds 1..256)
package prod_accum_pkg;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned SUM_W  = 40;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : prod_accum_pkg

// File: rtl/prod_accum.sv
// Block accumulator: sums up to MAX_LEN unsigned products per block and
// presents the sum and the product count on a valid/ready output.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   scan_en, scan_in   : scan shift enable and serial input
//   scan_out           : scan flop output
//   in_valid/in_ready  : product handshake; in_prod is the product,
//                        in_last marks the final product of a block
//   cfg_clear          : synchronous abort, overrides all handshakes
//   out_valid/out_ready: result handshake; out_sum / out_count payload
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              cfg_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic             LP_LEN_ONE = (MAX_LEN == 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_load_out;
  logic               r_out_valid;
  logic [SUM_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_scan;

  // Ready must drop in the same cycle cfg_clear is raised, so it is a decode.
  assign in_ready  = (r_state != HOLD) && !cfg_clear;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accumulator update and result capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load_out  = 1'b0;
    if (cfg_clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_acc_nxt = SUM_W'(in_prod);
            w_cnt_nxt = CNT_W'(1);
            if (in_last || LP_LEN_ONE) begin
              w_state_nxt = HOLD;
              w_load_out  = 1'b1;
            end else begin
              w_state_nxt = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            w_acc_nxt = r_acc + SUM_W'(in_prod);
            w_cnt_nxt = w_cnt_inc;
            if (in_last || (w_cnt_inc == LP_MAX_CNT)) begin
              w_state_nxt = HOLD;
              w_load_out  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Accumulator, registered outputs and scan flop.
  // out_sum/out_count are separate from acc/cnt so they keep their last
  // value after a clear or once a new block starts accumulating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_scan      <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == HOLD);
      if (w_load_out) begin
        r_out_sum   <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
      end
      if (scan_en) begin
        r_scan <= scan_in;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign scan_out  = r_scan;

endmodule : prod_accum

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: vector table, directed corner
// sequences and a randomized run against a block-level reference model.
module tb_prod_accum;

  localparam int unsigned MAX_LEN = 256;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        scan_en = 1'b0;
  logic        scan_in = 1'b0;
  logic        scan_out;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        cfg_clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_sum;
  logic [8:0]  out_count;

  prod_accum #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .cfg_clear (cfg_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        v;
    logic [31:0] p;
    logic        l;
    logic        clr;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [39:0] e_sum;
    logic [8:0]  e_cnt;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic l,
                       input logic clr, input logic ordy);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    cfg_clear = clr;
    out_ready = ordy;
  endtask

  // Reference model state: products of the open block, pending result
  logic [31:0] m_q[$];
  logic        m_hold;
  logic [39:0] m_sum;
  logic [8:0]  m_cnt;

  function automatic logic [39:0] q_sum();
    logic [39:0] s = '0;
    foreach (m_q[i]) s = s + 40'(m_q[i]);
    return s;
  endfunction

  initial begin
    int          bad_rdy;
    logic [2:0]  pat;
    logic        r_v, r_l, r_c, r_o;
    logic [31:0] r_p;

    // Reset values
    #2 rstn = 1'b0;
    tick();
    tick();
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_cnt", 64'(out_count), 64'd0);
    chk("rst_scan", 64'(scan_out), 64'd0);
    rstn = 1'b1;
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd1);

    // Burst 3,5,7; abort of 9; single-product blocks; no-bypass; clear in HOLD
    vt[0]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 40'd0,  9'd0};
    vt[1]  = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 40'd0,  9'd0};
    vt[2]  = '{1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 40'd15, 9'd3};
    vt[3]  = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'd15, 9'd3};
    vt[4]  = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 40'd15, 9'd3};
    vt[5]  = '{1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 40'd15, 9'd3};
    vt[6]  = '{1'b1, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 40'd15, 9'd3};
    vt[7]  = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 40'd4,  9'd1};
    vt[8]  = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'd4,  9'd1};
    vt[9]  = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'd4,  9'd1};
    vt[10] = '{1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 40'd2,  9'd1};
    vt[11] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40'd2,  9'd1};
    vt[12] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40'd2,  9'd1};
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].p, vt[i].l, vt[i].clr, vt[i].ordy);
      #1;
      chk($sformatf("tbl%0d_rdy", i), 64'(in_ready), 64'(vt[i].e_rdy));
      tick();
      chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(vt[i].e_ov));
      chk($sformatf("tbl%0d_sum", i), 64'(out_sum), 64'(vt[i].e_sum));
      chk($sformatf("tbl%0d_cnt", i), 64'(out_count), 64'(vt[i].e_cnt));
    end

    // Max length: 256 full-scale products, no in_last
    bad_rdy = 0;
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      #1;
      if (in_ready !== 1'b1) bad_rdy++;
      tick();
      if (k == 254) chk("max_ov_early", 64'(out_valid), 64'd0);
    end
    chk("max_rdy_during", 64'(bad_rdy), 64'd0);
    chk("max_ov", 64'(out_valid), 64'd1);
    chk("max_sum", 64'(out_sum), 64'h00FF_FFFF_FF00);
    chk("max_cnt", 64'(out_count), 64'd256);

    // Backpressure: 5 cycles of out_ready=0 with in_valid=1
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp%0d_rdy", j), 64'(in_ready), 64'd0);
      tick();
      chk($sformatf("bp%0d_ov", j), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_sum", j), 64'(out_sum), 64'h00FF_FFFF_FF00);
    end
    drive(1'b1, 32'd6, 1'b1, 1'b0, 1'b1);
    #1;
    chk("bp_xfer_rdy", 64'(in_ready), 64'd0);
    tick();
    chk("bp_xfer_ov", 64'(out_valid), 64'd0);
    drive(1'b1, 32'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bp_resume_rdy", 64'(in_ready), 64'd1);
    tick();
    chk("bp_resume_ov", 64'(out_valid), 64'd1);
    chk("bp_resume_sum", 64'(out_sum), 64'd6);
    chk("bp_resume_cnt", 64'(out_count), 64'd1);

    // Reset while holding a result
    rstn = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rsthold_ov", 64'(out_valid), 64'd0);
    chk("rsthold_sum", 64'(out_sum), 64'd0);
    chk("rsthold_cnt", 64'(out_count), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    chk("rsthold_rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd10, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rsthold_nov", 64'(out_valid), 64'd0);
    drive(1'b1, 32'd20, 1'b1, 1'b0, 1'b1);
    tick();
    chk("rsthold_blk_ov", 64'(out_valid), 64'd1);
    chk("rsthold_blk_sum", 64'(out_sum), 64'd30);
    chk("rsthold_blk_cnt", 64'(out_count), 64'd2);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rsthold_blk_done", 64'(out_valid), 64'd0);

    // Scan shift 1,0,1 then hold
    pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      scan_en = 1'b1;
      scan_in = pat[2-i];
      tick();
      chk($sformatf("scan%0d", i), 64'(scan_out), 64'(pat[2-i]));
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
    tick();
    tick();
    chk("scan_hold", 64'(scan_out), 64'd1);
    chk("scan_sum", 64'(out_sum), 64'd30);

    // Randomized run against the block-level model
    rstn = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tick();
    rstn = 1'b1;
    m_q.delete();
    m_hold = 1'b0;
    m_sum  = '0;
    m_cnt  = '0;
    for (int c = 0; c < 400; c++) begin
      r_v = ($urandom_range(0, 3) != 0);
      r_p = $urandom();
      r_l = ($urandom_range(0, 7) == 0);
      r_c = ($urandom_range(0, 39) == 0);
      r_o = 1'($urandom_range(0, 1));
      scan_en = 1'($urandom_range(0, 1));
      scan_in = 1'($urandom_range(0, 1));
      drive(r_v, r_p, r_l, r_c, r_o);
      #1;
      chk($sformatf("rnd%0d_rdy", c), 64'(in_ready), 64'(!m_hold && !r_c));
      tick();
      if (r_c) begin
        m_q.delete();
        m_hold = 1'b0;
      end else if (m_hold) begin
        if (r_o) m_hold = 1'b0;
      end else if (r_v) begin
        m_q.push_back(r_p);
        if (r_l || (m_q.size() == MAX_LEN)) begin
          m_hold = 1'b1;
          m_sum  = q_sum();
          m_cnt  = 9'(m_q.size());
          m_q.delete();
        end
      end
      chk($sformatf("rnd%0d_ov", c), 64'(out_valid), 64'(m_hold));
      chk($sformatf("rnd%0d_sum", c), 64'(out_sum), 64'(m_sum));
      chk($sformatf("rnd%0d_cnt", c), 64'(out_count), 64'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_prod_accum

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL use clock clk and reset rstn, asynchronous, active-low.
REQ-002 The ports SHALL be, in order:
- clk, in, 1, rising-edge clock.
- rstn, in, 1, asynchronous active-low reset.
- scan_en, in, 1, scan shift enable.
- scan_in, in, 1, scan serial input.
- scan_out, out, 1, scan serial output.
- in_valid, in, 1, product present.
- in_ready, out, 1, block accepts product.
- in_prod, in, 32, unsigned 32-bit product from the 16x16 multiplier stage.
- in_last, in, 1, final product of the current block.
- cfg_clear, in, 1, synchronous abort.
- out_valid, out, 1, result present.
- out_ready, in, 1, consumer accepts result.
- out_sum, out, 40, unsigned accumulated sum.
- out_count, out, 9, number of products in the block, 1..256.
REQ-003 The parameter MAX_LEN SHALL default to 256 and set the maximum number of products per block; the legal range is 1..256.

Function
REQ-004 A transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; likewise where out_valid=1 and out_ready=1.
REQ-005 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-006 IDLE:
- in_ready=1.
- On an input transfer: acc<=in_prod, cnt<=1, go to ACCUM.
- If in_last=1 or MAX_LEN=1 on that transfer, go to HOLD instead.
REQ-007 ACCUM:
- in_ready=1.
- On an input transfer: acc<=acc+in_prod, cnt<=cnt+1.
- If in_last=1 or cnt+1==MAX_LEN, go to HOLD.
REQ-008 HOLD:
- in_ready=0, out_valid=1.
- out_sum=acc and out_count=cnt, both held stable until the output transfer.
- On the output transfer, go to IDLE.
REQ-009 Latency: out_valid SHALL rise in the cycle after the terminating input transfer.
REQ-010 There SHALL be no same-cycle bypass from output transfer to new input; the next block's first product is accepted no earlier than the cycle after the output transfer.
REQ-011 Width rule: addition SHALL be 40-bit unsigned with zero-extended in_prod. Overflow is impossible because 256*(2^32-1) < 2^40.
REQ-012 When in_valid=0 in IDLE or ACCUM, state, acc and cnt SHALL hold.
REQ-013 out_valid SHALL be 0 outside HOLD. out_sum and out_count SHALL retain their last values outside HOLD.
REQ-014 cfg_clear=1 SHALL have priority over all handshakes in every state:
- next state IDLE, acc<=0, cnt<=0, out_valid<=0.
- Any concurrent input transfer is discarded.
- in_ready SHALL be 0 while cfg_clear=1.
REQ-015 The scan flop SHALL load scan_in on each edge when scan_en=1 and hold otherwise. scan_out SHALL equal the scan flop output.
REQ-016 scan_en SHALL NOT affect the datapath or the FSM.

Reset
REQ-017 On rstn=0 the block SHALL immediately reach:
- state IDLE, acc=0, cnt=0.
- out_valid=0, out_sum=0, out_count=0.
- scan flop=0.
REQ-018 A reset asserted mid-block or in HOLD SHALL discard the partial or pending result. No output transfer of it SHALL occur after reset release.
REQ-019 in_ready SHALL be 1 in the first cycle after rstn deasserts, unless cfg_clear=1.

Structure
REQ-020 A shared package SHALL hold:
- the state enum (IDLE, ACCUM, HOLD).
- constants PROD_W=32, SUM_W=40, CNT_W=9.
REQ-021 The design SHALL be a single module with no sub-module.

Verification
REQ-022 Burst: products 3, 5 and 7 (7 with in_last), out_ready=1 -> out_sum=15, out_count=3, out_valid high exactly one cycle, starting the cycle after the transfer of 7.
REQ-023 Max length: 256 products of 32'hFFFFFFFF without in_last -> after the 256th, out_sum=40'hFF_FFFF_FF00, out_count=256, in_ready=0.
REQ-024 Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 throughout and out_sum stable; accepting resumes the cycle after out_ready=1.
REQ-025 Abort: cfg_clear=1 in the same cycle as an in_valid of 9 in ACCUM -> 9 discarded. A following block of a single product 4 with in_last -> out_sum=4, out_count=1.
REQ-026 Reset in HOLD: assert rstn=0 while out_valid=1 -> out_valid=0 asynchronously and out_sum=0; the next block accumulates from 0.
REQ-027 Scan: scan_en=1 with scan_in pattern 1,0,1 -> scan_out shows 1,0,1 one cycle delayed; scan_en=0 -> scan_out holds and out_sum is unaffected.
